// File: rtl/orient_hist_peak_pkg.sv
// Shared constants, state encoding and direction-code/bin-index conversion
// for the orientation histogram peak finder.
package orient_hist_peak_pkg;

  localparam int unsigned NUM_BINS = 32;
  localparam int unsigned DIR_W    = 5;
  localparam int unsigned BIN_W    = 5;
  localparam int unsigned SCAN_W   = BIN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Two's complement code -16..+15 maps to offset-binary bin 0..31.
  function automatic logic [BIN_W-1:0] dir_to_bin(input logic [DIR_W-1:0] dir);
    return {~dir[DIR_W-1], dir[DIR_W-2:0]};
  endfunction

  function automatic logic [DIR_W-1:0] bin_to_dir(input logic [BIN_W-1:0] bin);
    return {~bin[BIN_W-1], bin[BIN_W-2:0]};
  endfunction

endpackage

// File: rtl/orient_hist_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones instead of wrapping.
module orient_hist_sat_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum_c
);

  logic [W:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum_c = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/orient_hist_peak.sv
// Accumulates magnitude-weighted direction samples into a 32-bin histogram,
// then scans it for the dominant bin and holds the result until consumed.
module orient_hist_peak
  import orient_hist_peak_pkg::*;
#(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIR_W-1:0] in_dir,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIR_W-1:0] out_dir,
  output logic [ACC_W-1:0] out_peak
);

  state_t               r_state;
  logic [ACC_W-1:0]     r_bins [NUM_BINS];
  logic [SCAN_W-1:0]    r_scan_idx;
  logic [ACC_W-1:0]     r_max;
  logic [BIN_W-1:0]     r_max_idx;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DIR_W-1:0]     r_out_dir;
  logic [ACC_W-1:0]     r_out_peak;

  logic                 w_accept;
  logic [BIN_W-1:0]     w_bin;
  logic [ACC_W-1:0]     w_sum;
  logic [BIN_W-1:0]     w_scan_bin;
  logic [ACC_W-1:0]     w_scan_val;

  assign w_accept   = in_valid & r_in_ready;
  assign w_bin      = dir_to_bin(in_dir);
  assign w_scan_bin = r_scan_idx[BIN_W-1:0];
  assign w_scan_val = r_bins[w_scan_bin];

  orient_hist_sat_add #(
    .W(ACC_W)
  ) u_sat_add (
    .i_a     (r_bins[w_bin]),
    .i_b     (ACC_W'(in_mag)),
    .o_sum_c (w_sum)
  );

  // Window control: clear, accumulate, scan bins 0..31, then publish and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_scan_idx  <= '0;
      r_max       <= '0;
      r_max_idx   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_dir   <= '0;
      r_out_peak  <= '0;
      for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
            r_in_ready <= 1'b1;
            r_state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_bins[w_bin] <= w_sum;
            if (in_last) begin
              r_in_ready <= 1'b0;
              r_scan_idx <= '0;
              r_max      <= '0;
              r_max_idx  <= '0;
              r_state    <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          // Index 32 is the publish step after the last bin has been compared.
          if (r_scan_idx == SCAN_W'(NUM_BINS)) begin
            r_out_dir   <= bin_to_dir(r_max_idx);
            r_out_peak  <= r_max;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            if (w_scan_val > r_max) begin
              r_max     <= w_scan_val;
              r_max_idx <= w_scan_bin;
            end
            r_scan_idx <= r_scan_idx + SCAN_W'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_dir   = r_out_dir;
  assign out_peak  = r_out_peak;

endmodule

// File: tb/tb_orient_hist_peak.sv
// Bench for orient_hist_peak: two instances (ACC_W=16 and ACC_W=8) share the
// same stimulus; expected results are queued per window and checked on output.
module tb_orient_hist_peak;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [4:0]  in_dir;
  logic [7:0]  in_mag;
  logic        in_last;
  logic        out_ready;

  logic        in_ready16, out_valid16;
  logic [4:0]  out_dir16;
  logic [15:0] out_peak16;
  logic        in_ready8, out_valid8;
  logic [4:0]  out_dir8;
  logic [7:0]  out_peak8;

  always #5 clk = ~clk;

  orient_hist_peak #(.MAG_W(8), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready16), .in_dir(in_dir), .in_mag(in_mag), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready), .out_dir(out_dir16),
    .out_peak(out_peak16)
  );

  orient_hist_peak #(.MAG_W(8), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready8), .in_dir(in_dir), .in_mag(in_mag), .in_last(in_last),
    .out_valid(out_valid8), .out_ready(out_ready), .out_dir(out_dir8),
    .out_peak(out_peak8)
  );

  typedef struct {
    logic [4:0]  dir16;
    logic [15:0] peak16;
    logic [4:0]  dir8;
    logic [7:0]  peak8;
  } exp_t;

  typedef struct {
    int              n;
    logic [3:0][4:0] dir;
    logic [3:0][7:0] mag;
    exp_t            exp;
  } win_t;

  exp_t sb_q[$];
  win_t tbl[4];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [4:0] d, input logic [7:0] m, input logic l, input logic v);
    @(negedge clk);
    in_valid = v; in_dir = d; in_mag = m; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] d16, input logic [15:0] p16,
                          input logic [4:0] d8, input logic [7:0] p8);
    exp_t e;
    e.dir16 = d16; e.peak16 = p16; e.dir8 = d8; e.peak8 = p8;
    sb_q.push_back(e);
  endtask

  // Called right after the edge that accepted the last sample.
  task automatic collect(input string name);
    int   lat = 0;
    exp_t e;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid16) begin lat = k; break; end
    end
    if (lat == 0) begin
      n_total++;
      $display("FAIL %s_timeout: out_valid not seen within 40 cycles, expected at 33", name);
      return;
    end
    check({name, "_latency"}, 32'(lat), 32'd33);
    check({name, "_valid8"}, 32'(out_valid8), 32'd1);
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_scoreboard: result with no expected entry, got dir 0x%0h", name, out_dir16);
      return;
    end
    e = sb_q.pop_front();
    check({name, "_dir16"},  32'(out_dir16),  32'(e.dir16));
    check({name, "_peak16"}, 32'(out_peak16), 32'(e.peak16));
    check({name, "_dir8"},   32'(out_dir8),   32'(e.dir8));
    check({name, "_peak8"},  32'(out_peak8),  32'(e.peak8));
    if (out_ready) begin
      @(posedge clk); #1;
      check({name, "_valid_drop"}, 32'(out_valid16), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_dir = '0;
    in_mag = '0; in_last = 1'b0; out_ready = 1'b1;

    // Expected values derived by hand from the offset-binary bin mapping.
    tbl[0].n = 3; tbl[0].dir = {5'h00, 5'h1d, 5'h03, 5'h03};
    tbl[0].mag = {8'd0, 8'd25, 8'd20, 8'd10};
    tbl[0].exp = '{dir16: 5'h03, peak16: 16'd30, dir8: 5'h03, peak8: 8'd30};
    tbl[1].n = 2; tbl[1].dir = {5'h00, 5'h00, 5'h02, 5'h1f};
    tbl[1].mag = {8'd0, 8'd0, 8'd7, 8'd7};
    tbl[1].exp = '{dir16: 5'h1f, peak16: 16'd7, dir8: 5'h1f, peak8: 8'd7};
    tbl[2].n = 2; tbl[2].dir = {5'h00, 5'h00, 5'h07, 5'h05};
    tbl[2].mag = {8'd0, 8'd0, 8'd0, 8'd0};
    tbl[2].exp = '{dir16: 5'h10, peak16: 16'd0, dir8: 5'h10, peak8: 8'd0};
    tbl[3].n = 4; tbl[3].dir = {5'h10, 5'h10, 5'h0f, 5'h0f};
    tbl[3].mag = {8'd10, 8'd255, 8'd100, 8'd200};
    tbl[3].exp = '{dir16: 5'h0f, peak16: 16'd300, dir8: 5'h10, peak8: 8'd255};

    #22;
    check("rst_in_ready",  32'(in_ready16),  32'd0);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_out_dir",   32'(out_dir16),   32'd0);
    check("rst_out_peak",  32'(out_peak16),  32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int w = 0; w < 4; w++) begin
      do_start();
      check($sformatf("win%0d_in_ready", w), 32'(in_ready16), 32'd1);
      for (int i = 0; i < tbl[w].n; i++) begin
        if (i == tbl[w].n - 1)
          push_exp(tbl[w].exp.dir16, tbl[w].exp.peak16, tbl[w].exp.dir8, tbl[w].exp.peak8);
        send(tbl[w].dir[i], tbl[w].mag[i], 1'(i == tbl[w].n - 1), 1'b1);
      end
      check($sformatf("win%0d_ready_low", w), 32'(in_ready16), 32'd0);
      collect($sformatf("win%0d", w));
    end

    // Saturation: 300 x 255 into one bin clamps in both widths.
    do_start();
    for (int i = 0; i < 299; i++) send(5'h00, 8'd255, 1'b0, 1'b1);
    push_exp(5'h00, 16'hffff, 5'h00, 8'hff);
    send(5'h00, 8'd255, 1'b1, 1'b1);
    collect("sat");

    // Gapped valid with in_last on idle cycles must not end the window.
    do_start();
    send(5'h04, 8'd5, 1'b0, 1'b1);
    send(5'h06, 8'd99, 1'b1, 1'b0);
    check("gap_ready_after_invalid_last", 32'(in_ready16), 32'd1);
    send(5'h04, 8'd6, 1'b0, 1'b1);
    send(5'h06, 8'd99, 1'b1, 1'b0);
    check("gap_ready_after_invalid_last2", 32'(in_ready16), 32'd1);
    push_exp(5'h04, 16'd11, 5'h04, 8'd11);
    send(5'h06, 8'd3, 1'b1, 1'b1);
    collect("gap");

    // Backpressure with start pulses during HOLD.
    out_ready = 1'b0;
    do_start();
    push_exp(5'h08, 16'd9, 5'h08, 8'd9);
    send(5'h08, 8'd9, 1'b1, 1'b1);
    collect("bp");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); start = 1'(c % 2);
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", c), 32'(out_valid16), 32'd1);
      check($sformatf("bp_hold%0d_dir", c),   32'(out_dir16),   32'h08);
      check($sformatf("bp_hold%0d_peak", c),  32'(out_peak16),  32'd9);
    end
    @(negedge clk); start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 32'(out_valid16), 32'd0);
    check("bp_idle_ready", 32'(in_ready16),  32'd0);
    @(posedge clk); #1;
    check("bp_idle_ready2", 32'(in_ready16), 32'd0);

    // Reset mid-SCAN clears outputs at once; next window has no residue.
    do_start();
    send(5'h05, 8'd50, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_mid_valid", 32'(out_valid16), 32'd0);
    check("rst_mid_ready", 32'(in_ready16),  32'd0);
    check("rst_mid_dir",   32'(out_dir16),   32'd0);
    check("rst_mid_peak",  32'(out_peak16),  32'd0);
    @(negedge clk); rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("rst_first_start", 32'(in_ready16), 32'd1);
    push_exp(5'h0a, 16'd4, 5'h0a, 8'd4);
    send(5'h0a, 8'd4, 1'b1, 1'b1);
    collect("post_rst");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
